uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lends one UART byte transmitter to NUM_REQ sources a whole message at a time
//   clk, rst                 : clock, asynchronous active-high reset
//   reqValid/reqData/reqLast : per-requester byte offer (8-bit lane per requester, last-byte flag)
//   reqReady                 : combinational accept strobe to the current owner
//   grant                    : one-hot transmitter owner, zero when free
//   txStart/txData/txBusy    : byte interface to the UART transmitter
//   timeoutPulse             : owner went silent for IDLE_LIMIT cycles and lost its grant
module uart_tx_arbiter #(
  parameter int          NUM_REQ    = 3,
  parameter int unsigned IDLE_LIMIT = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [8*NUM_REQ-1:0]   reqData,
  input  logic [NUM_REQ-1:0]     reqLast,
  output logic [NUM_REQ-1:0]     reqReady,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   txStart,
  output logic [7:0]             txData,
  input  logic                   txBusy,
  output logic                   timeoutPulse
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [31:0] LIM = 32'(IDLE_LIMIT);
  typedef enum logic [2:0] {IDLE, ARB, WAIT_BYTE, START, BUSY_HI, BUSY_LO} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, next_ptr;
  logic [31:0] idle_cnt, idle_n, idle_inc;
  logic last_flag, last_n, to_n, own_valid, own_last, accept, expire;
  logic [7:0] own_data, data_n;
  logic [NUM_REQ-1:0] grant_n, pick;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      idle_cnt     <= '0;
      last_flag    <= 1'b0;
      grant        <= '0;
      txData       <= 8'h00;
      timeoutPulse <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      idle_cnt     <= idle_n;
      last_flag    <= last_n;
      grant        <= grant_n;
      txData       <= data_n;
      timeoutPulse <= to_n;
    end
  // Owner lane mux plus the wrap-around search; the lowest distance from ptr is assigned last and wins.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    next_ptr  = ptr;
    pick      = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        own_valid = reqValid[i];
        own_last  = reqLast[i];
        own_data  = reqData[8*i +: 8];
        next_ptr  = PW'((i + 1) % NUM_REQ);
      end
    for (int d = NUM_REQ - 1; d >= 0; d--)
      for (int i = 0; i < NUM_REQ; i++)
        if (i == (int'(ptr) + d) % NUM_REQ && reqValid[i]) pick = NUM_REQ'(1) << i;
  end
  assign accept   = (state == WAIT_BYTE) && own_valid && !txBusy;
  assign idle_inc = (idle_cnt >= LIM) ? LIM : idle_cnt + 32'd1;
  assign expire   = (state == WAIT_BYTE) && !accept && (idle_inc >= LIM);
  assign reqReady = accept ? grant : '0;
  assign txStart  = (state == START);
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idle_n  = idle_cnt;
    last_n  = last_flag;
    grant_n = grant;
    data_n  = txData;
    to_n    = 1'b0;
    case (state)
      IDLE:      state_n = |reqValid ? ARB : IDLE;
      ARB:
        if (|reqValid) begin
          grant_n = pick;
          idle_n  = '0;
          state_n = WAIT_BYTE;
        end else state_n = IDLE;
      WAIT_BYTE:
        if (accept) begin
          data_n  = own_data;
          last_n  = own_last;
          idle_n  = '0;
          state_n = START;
        end else if (expire) begin
          to_n    = 1'b1;
          grant_n = '0;
          ptr_n   = next_ptr;
          idle_n  = idle_inc;
          state_n = IDLE;
        end else idle_n = idle_inc;
      START:     state_n = BUSY_HI;
      BUSY_HI:   state_n = txBusy ? BUSY_LO : BUSY_HI;
      BUSY_LO:
        if (!txBusy) begin
          grant_n = last_flag ? '0 : grant;
          ptr_n   = last_flag ? next_ptr : ptr;
          state_n = last_flag ? IDLE : WAIT_BYTE;
        end
      default:   state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a 10-cycle UART busy model
module tb_uart_tx_arbiter;
  typedef struct {int owner; logic [7:0] data;} exp_t;
  typedef struct {logic [7:0] data; logic last;} byte_t;
  logic clk = 1'b0, rst = 1'b1, txStart, txBusy, timeoutPulse;
  logic [2:0] reqValid, reqLast, reqReady, grant, acc, prev_grant;
  logic [23:0] reqData;
  logic [7:0] txData;
  int tests_run = 0, fails = 0, cyc = 0, starts = 0, gchg = 0, to_cnt = 0, to_gap = -1, last_start = 0, busy_cnt = 0;
  int rdy_cnt [3];
  logic [2:0] to_grant;
  byte_t req_q [3][$];
  exp_t exp_q [$];
  exp_t e;
  uart_tx_arbiter #(.NUM_REQ(3), .IDLE_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqReady(reqReady), .grant(grant), .txStart(txStart), .txData(txData),
    .txBusy(txBusy), .timeoutPulse(timeoutPulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (txStart) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  assign txBusy = busy_cnt != 0;
  initial begin
    reqValid = '0; reqData = '0; reqLast = '0; acc = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (acc[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (req_q[i].size() > 0) begin
          reqValid[i] = 1'b1; reqData[8*i +: 8] = req_q[i][0].data; reqLast[i] = req_q[i][0].last;
        end else begin
          reqValid[i] = 1'b0; reqLast[i] = 1'b0;
        end
      end
      #3;
      acc = reqReady;
      for (int i = 0; i < 3; i++) if (acc[i]) rdy_cnt[i]++;
      tests_run++;
      if ((reqReady & ~grant) !== 3'b000) begin
        fails++; $display("FAIL ready_to_non_owner reqReady=%b grant=%b", reqReady, grant);
      end
    end
  end
  initial prev_grant = '0;
  always @(negedge clk) begin
    cyc++;
    tests_run++;
    if ((txStart && txBusy) || !$onehot0(grant)) begin
      fails++; $display("FAIL protocol txStart=%b txBusy=%b grant=%b", txStart, txBusy, grant);
    end
    if (txStart) begin
      starts++; last_start = cyc; tests_run++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL unexpected_txstart txData=%h grant=%b", txData, grant);
      end else begin
        e = exp_q.pop_front();
        if (txData !== e.data || grant !== (3'b001 << e.owner)) begin
          fails++; $display("FAIL tx_byte got data=%h grant=%b want data=%h grant=%b", txData, grant, e.data, 3'b001 << e.owner);
        end
      end
    end
    if (timeoutPulse) begin to_cnt++; to_gap = cyc - last_start; to_grant = grant; end
    if (grant !== prev_grant) gchg++;
    prev_grant = grant;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic push(input int r, input logic [7:0] d, input logic l, input bit expect_tx);
    byte_t b;
    exp_t x;
    b.data = d; b.last = l; req_q[r].push_back(b);
    x.owner = r; x.data = d;
    if (expect_tx) exp_q.push_back(x);
  endtask
  task automatic clr_counts();
    for (int i = 0; i < 3; i++) rdy_cnt[i] = 0;
  endtask
  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0 && req_q[0].size() == 0 && req_q[1].size() == 0 && req_q[2].size() == 0 && grant == 3'b000 && !txBusy) begin
        ok = 1'b1; break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests_run += 5;
    if (grant !== 3'b000) begin fails++; $display("FAIL reset_grant got=%b want=000", grant); end
    if (reqReady !== 3'b000) begin fails++; $display("FAIL reset_ready got=%b want=000", reqReady); end
    if (txStart !== 1'b0) begin fails++; $display("FAIL reset_txstart got=%b want=0", txStart); end
    if (txData !== 8'h00) begin fails++; $display("FAIL reset_txdata got=%h want=00", txData); end
    if (timeoutPulse !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b want=0", timeoutPulse); end
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_single();
    bit ok;
    int g0, s0;
    clr_counts(); g0 = gchg; s0 = starts;
    push(1, 8'h31, 1'b0, 1'b1);
    push(1, 8'h0A, 1'b1, 1'b1);
    wait_done(300, ok);
    tests_run += 4;
    if (!ok) begin fails++; $display("FAIL single_done got=0 want=1"); end
    if (rdy_cnt[1] != 2) begin fails++; $display("FAIL single_ready got=%0d want=2", rdy_cnt[1]); end
    if (gchg - g0 != 2) begin fails++; $display("FAIL single_grant_held changes=%0d want=2", gchg - g0); end
    if (starts - s0 != 2) begin fails++; $display("FAIL single_starts got=%0d want=2", starts - s0); end
  endtask
  task automatic test_ptr_after_single();
    bit ok;
    clr_counts();
    push(0, 8'h40, 1'b1, 1'b0);
    push(2, 8'h42, 1'b1, 1'b0);
    exp_q.push_back('{2, 8'h42});
    exp_q.push_back('{0, 8'h40});
    wait_done(300, ok);
    tests_run += 2;
    if (!ok) begin fails++; $display("FAIL ptr2_done got=0 want=1"); end
    if (rdy_cnt[0] != 1 || rdy_cnt[2] != 1) begin fails++; $display("FAIL ptr2_ready got=%0d,%0d want=1,1", rdy_cnt[0], rdy_cnt[2]); end
  endtask
  task automatic test_contention();
    bit ok;
    rst = 1'b1;
    clr_counts();
    push(0, 8'hA0, 1'b1, 1'b1);
    push(1, 8'hA1, 1'b1, 1'b1);
    push(2, 8'hA2, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done(400, ok);
    tests_run += 2;
    if (!ok) begin fails++; $display("FAIL contention_done got=0 want=1"); end
    if (rdy_cnt[0] != 1 || rdy_cnt[1] != 1 || rdy_cnt[2] != 1) begin
      fails++; $display("FAIL contention_ready got=%0d,%0d,%0d want=1,1,1", rdy_cnt[0], rdy_cnt[1], rdy_cnt[2]);
    end
  endtask
  task automatic test_round_robin();
    bit ok;
    push(0, 8'hB0, 1'b1, 1'b1);
    push(2, 8'hB2, 1'b1, 1'b1);
    wait_done(300, ok);
    tests_run++;
    if (!ok) begin fails++; $display("FAIL rr_done got=0 want=1"); end
  endtask
  task automatic test_timeout();
    bit ok;
    int t0;
    t0 = to_cnt;
    push(0, 8'h55, 1'b0, 1'b1);
    push(1, 8'h66, 1'b1, 1'b1);
    wait_done(300, ok);
    tests_run += 4;
    if (!ok) begin fails++; $display("FAIL timeout_done got=0 want=1"); end
    if (to_cnt - t0 != 1) begin fails++; $display("FAIL timeout_count got=%0d want=1", to_cnt - t0); end
    if (to_gap != 20) begin fails++; $display("FAIL timeout_latency got=%0d want=20 cycles after txStart", to_gap); end
    if (to_grant !== 3'b000) begin fails++; $display("FAIL timeout_grant got=%b want=000", to_grant); end
  endtask
  task automatic test_reset_mid();
    bit ok, hit;
    int s0;
    s0 = starts; hit = 1'b0;
    push(1, 8'h11, 1'b0, 1'b1);
    push(1, 8'h22, 1'b0, 1'b1);
    push(1, 8'h33, 1'b0, 1'b1);
    push(1, 8'h44, 1'b1, 1'b1);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); #1;
      if (starts - s0 >= 2) begin hit = 1'b1; break; end
    end
    tests_run++;
    if (!hit) begin fails++; $display("FAIL midreset_second_start got=%0d want=2", starts - s0); end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    req_q[1].delete();
    exp_q.delete();
    tests_run += 4;
    if (grant !== 3'b000) begin fails++; $display("FAIL midreset_grant got=%b want=000", grant); end
    if (txStart !== 1'b0) begin fails++; $display("FAIL midreset_txstart got=%b want=0", txStart); end
    if (txData !== 8'h00) begin fails++; $display("FAIL midreset_txdata got=%h want=00", txData); end
    if (reqReady !== 3'b000) begin fails++; $display("FAIL midreset_ready got=%b want=000", reqReady); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    clr_counts();
    repeat (15) @(negedge clk);
    tests_run++;
    if (starts != s0) begin fails++; $display("FAIL midreset_quiet starts=%0d want=0", starts - s0); end
    push(0, 8'h77, 1'b1, 1'b1);
    push(2, 8'h88, 1'b1, 1'b1);
    wait_done(300, ok);
    tests_run += 2;
    if (!ok) begin fails++; $display("FAIL midreset_restart_done got=0 want=1"); end
    if (rdy_cnt[0] != 1 || rdy_cnt[1] != 0 || rdy_cnt[2] != 1) begin
      fails++; $display("FAIL midreset_ready got=%0d,%0d,%0d want=1,0,1", rdy_cnt[0], rdy_cnt[1], rdy_cnt[2]);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_ptr_after_single();
    test_contention();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
